// File: rtl/parking_lot_pkg.sv
// parking_lot_pkg: shared FSM states, completion codes and timestamp width
package parking_lot_pkg;
   localparam int TS_W = 16;
   typedef enum logic [2:0] {ST_IDLE, ST_GO, ST_SERVE, ST_RETURN, ST_DONE} state_t;
   localparam logic [1:0] DC_OK    = 2'd0;
   localparam logic [1:0] DC_FULL  = 2'd1;
   localparam logic [1:0] DC_BAD   = 2'd2;
   localparam logic [1:0] DC_ABORT = 2'd3;
endpackage

// File: rtl/parking_req_fifo.sv
// parking_req_fifo: first-word-fall-through request queue, push and pop legal in one cycle
module parking_req_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   assign empty = wr_ptr == rd_ptr;
   assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
   assign rd_data = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clock)
      if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/parking_lot_ctrl_p.sv
// parking_lot_ctrl_p: queued automated parking lot with one elevator, slot store,
// exit fees and per-floor leak blocking
module parking_lot_ctrl_p
   import parking_lot_pkg::*;
#(
   parameter int NUM_FLOORS = 7,
   parameter int SLOTS = 2,
   parameter int PLATE_W = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int N_SLOT = NUM_FLOORS * SLOTS,
   localparam int CNT_W = $clog2(N_SLOT + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_in,
   input  logic [PLATE_W-1:0]        req_plate,
   input  logic                      leak,
   input  logic [2:0]                leak_floor,
   input  logic                      leak_clear,
   output logic [2:0]                current_floor,
   output logic [PLATE_W-1:0]        moving,
   output logic                      done_valid,
   output logic [1:0]                done_code,
   output logic [7:0]                fee,
   output logic [N_SLOT*PLATE_W-1:0] parked,
   output logic [CNT_W-1:0]          free_count,
   output logic                      full,
   output logic [NUM_FLOORS-1:0]     blocked
);
   state_t state, state_n;
   logic [PLATE_W-1:0] slot_plate [N_SLOT];
   logic [TS_W-1:0] slot_time [N_SLOT];
   logic [TS_W-1:0] ts, age;
   logic [PLATE_W:0] q_data;
   logic [PLATE_W-1:0] q_plate, plate;
   logic q_enter, q_empty, q_full, pop, is_enter;
   logic hit, free_hit, bad, rej, abort;
   logic [CNT_W-1:0] hit_idx, free_idx, tgt_idx;
   logic [2:0] hit_floor, free_floor, tgt_floor;
   logic [NUM_FLOORS-1:0] leak_mask;
   assign req_ready = reset && !q_full;
   assign {q_enter, q_plate} = q_data;
   assign done_valid = state == ST_DONE;
   assign full = free_count == '0;
   assign bad = q_enter ? (q_plate == '0 || hit) : !hit;
   assign rej = bad || (q_enter && !free_hit);
   assign abort = is_enter && blocked[tgt_floor - 3'd1];
   assign age = ts - slot_time[tgt_idx];
   parking_req_fifo #(.WIDTH(PLATE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (req_valid && req_ready),
      .pop     (pop),
      .wr_data ({req_in, req_plate}),
      .rd_data (q_data),
      .empty   (q_empty),
      .full    (q_full)
   );
   for (genvar i = 0; i < N_SLOT; i++) assign parked[i*PLATE_W +: PLATE_W] = slot_plate[i];
   // descending scan leaves the lowest matching index, i.e. lowest floor then lowest slot
   always_comb begin
      hit = 1'b0;
      hit_idx = '0;
      hit_floor = '0;
      free_hit = 1'b0;
      free_idx = '0;
      free_floor = '0;
      free_count = '0;
      for (int i = N_SLOT - 1; i >= 0; i--) begin
         if (q_plate != '0 && slot_plate[i] == q_plate) begin
            hit = 1'b1;
            hit_idx = CNT_W'(i);
            hit_floor = 3'(i / SLOTS + 1);
         end
         if (slot_plate[i] == '0 && !blocked[i / SLOTS]) begin
            free_hit = 1'b1;
            free_idx = CNT_W'(i);
            free_floor = 3'(i / SLOTS + 1);
         end
         free_count = free_count + CNT_W'(slot_plate[i] == '0);
      end
   end
   always_comb begin
      leak_mask = '0;
      for (int f = 0; f < NUM_FLOORS; f++) leak_mask[f] = leak && leak_floor == 3'(f + 1);
   end
   // rejections pass through RETURN at floor 0 so they complete one cycle later
   always_comb begin
      state_n = state;
      pop = 1'b0;
      case (state)
         ST_IDLE: begin
            pop = !q_empty;
            state_n = q_empty ? ST_IDLE : rej ? ST_RETURN : ST_GO;
         end
         ST_GO:     state_n = abort ? ST_RETURN : current_floor == tgt_floor ? ST_SERVE : ST_GO;
         ST_SERVE:  state_n = ST_RETURN;
         ST_RETURN: state_n = current_floor <= 3'd1 ? ST_DONE : ST_RETURN;
         default:   state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= ST_IDLE;
         current_floor <= '0;
         moving <= '0;
         done_code <= DC_OK;
         fee <= '0;
         ts <= '0;
         blocked <= '0;
         is_enter <= 1'b0;
         plate <= '0;
         tgt_floor <= '0;
         tgt_idx <= '0;
         for (int i = 0; i < N_SLOT; i++) begin
            slot_plate[i] <= '0;
            slot_time[i] <= '0;
         end
      end else begin
         state <= state_n;
         ts <= ts + 1'b1;
         blocked <= leak_mask | (blocked & {NUM_FLOORS{!leak_clear}});
         case (state)
            ST_IDLE: if (pop) begin
               is_enter <= q_enter;
               plate <= q_plate;
               fee <= '0;
               done_code <= !rej ? DC_OK : bad ? DC_BAD : DC_FULL;
               tgt_floor <= q_enter ? free_floor : hit_floor;
               tgt_idx <= q_enter ? free_idx : hit_idx;
               moving <= q_enter && !rej ? q_plate : '0;
            end
            ST_GO: begin
               done_code <= abort ? DC_ABORT : done_code;
               current_floor <= !abort && current_floor != tgt_floor ? current_floor + 3'd1 : current_floor;
            end
            ST_SERVE: begin
               slot_plate[tgt_idx] <= is_enter ? plate : '0;
               if (is_enter) slot_time[tgt_idx] <= ts;
               moving <= is_enter ? '0 : plate;
               if (!is_enter) fee <= |age[TS_W-1:8] ? 8'hFF : age[7:0];
            end
            ST_RETURN: current_floor <= current_floor != 3'd0 ? current_floor - 3'd1 : current_floor;
            ST_DONE: moving <= '0;
            default: ;
         endcase
      end
   end
endmodule
